// File: rtl/const_div_seq.sv
// const_div_seq: divides a WIDTH-bit unsigned dividend by the constant DIVISOR,
//   retiring CHUNK quotient bits per cycle (MSB chunk first) and carrying the
//   partial remainder between chunks.
// Latency: NCH = ceil(WIDTH/CHUNK) cycles from the accepting edge to out_valid.
//   With CONST_DIV_ZERO_SKIP_EN defined, all-zero leading chunks are skipped
//   and latency is (highest nonzero chunk + 1), minimum 1.
// Backpressure: valid/ready on both sides. The result is held in DONE until
//   out_ready. in_ready = IDLE | (DONE & out_ready), so back-to-back accepts
//   happen on the same edge that retires the previous result.
// Ports: clk, rst (sync, active high), in_valid/in_ready/dividend,
//   out_valid/out_ready/quotient/remainder.
module const_div_seq #(
   parameter int WIDTH   = 64,
   parameter int DIVISOR = 3,
   parameter int CHUNK   = 6,
   parameter int REM_W   = $clog2(DIVISOR)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] dividend,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] quotient,
   output logic [REM_W-1:0] remainder
);

   localparam int NCH = (WIDTH + CHUNK - 1) / CHUNK;
   localparam int PW  = NCH * CHUNK;
   localparam int IW  = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int TW  = REM_W + CHUNK;

   typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

   state_t           state, state_next;
   logic [PW-1:0]    dreg;
   logic [REM_W-1:0] r;
   logic [IW-1:0]    idx;
   logic [IW-1:0]    start_idx;
   logic [WIDTH-1:0] q_reg;
   logic [WIDTH-1:0] q_next;
   logic [REM_W-1:0] rem_reg;
   logic [PW-1:0]    din_pad;
   logic [CHUNK-1:0] cur_chunk;
   logic [TW-1:0]    t;
   logic [CHUNK-1:0] qchunk;
   logic [REM_W-1:0] r_next;
   logic             accept;
   logic             last;
`ifdef CONST_DIV_ZERO_SKIP_EN
   logic             first;
`endif

   assign accept    = in_valid & in_ready;
   assign last      = (idx == '0);
   assign quotient  = q_reg;
   assign remainder = rem_reg;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_next;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (in_valid) state_next = BUSY;
         BUSY:    if (last) state_next = DONE;
         DONE:    if (out_ready) state_next = in_valid ? BUSY : IDLE;
         default: state_next = IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: in_ready = 1'b1;
         DONE: begin
            out_valid = 1'b1;
            in_ready  = out_ready;
         end
         default: ;
      endcase
   end

   // ---------------- Datapath ----------------
   // Zero-extend so the MSB chunk carries the padding.
   assign din_pad = PW'(dividend);

   // Starting chunk index: always the top chunk, or the highest nonzero chunk
   // when leading-zero skipping is enabled (r = 0 is exact for skipped chunks).
`ifdef CONST_DIV_ZERO_SKIP_EN
   always_comb begin
      start_idx = '0;
      for (int j = 0; j < NCH; j++) begin
         if (|din_pad[j*CHUNK +: CHUNK]) start_idx = IW'(j);
      end
   end
`else
   assign start_idx = IW'(NCH - 1);
`endif

   // r < DIVISOR, so t fits REM_W+CHUNK bits and t/DIVISOR fits CHUNK bits.
   assign cur_chunk = dreg[int'(idx)*CHUNK +: CHUNK];
   assign t         = {r, cur_chunk};
   assign qchunk    = CHUNK'(t / TW'(DIVISOR));
   assign r_next    = REM_W'(t % TW'(DIVISOR));

   // Merge the new quotient chunk; bits of the top chunk beyond WIDTH drop out.
   always_comb begin
      q_next = q_reg;
      for (int b = 0; b < WIDTH; b++) begin
         if (b / CHUNK == int'(idx)) q_next[b] = qchunk[b % CHUNK];
`ifdef CONST_DIV_ZERO_SKIP_EN
         // First BUSY cycle: zero the skipped upper chunks of the old result.
         if (first && (b / CHUNK > int'(idx))) q_next[b] = 1'b0;
`endif
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         dreg    <= '0;
         r       <= '0;
         idx     <= '0;
         q_reg   <= '0;
         rem_reg <= '0;
`ifdef CONST_DIV_ZERO_SKIP_EN
         first   <= 1'b0;
`endif
      end else if (accept) begin
         dreg    <= din_pad;
         r       <= '0;
         idx     <= start_idx;
`ifdef CONST_DIV_ZERO_SKIP_EN
         first   <= 1'b1;
`endif
      end else if (state == BUSY) begin
         r       <= r_next;
         q_reg   <= q_next;
`ifdef CONST_DIV_ZERO_SKIP_EN
         first   <= 1'b0;
`endif
         if (last) rem_reg <= r_next;
         else      idx     <= idx - 1'b1;
      end
   end

endmodule

// File: doc/const_div_seq.md
Name: const_div_seq

Overview:
- Sequential, parametrised successor to the combinational quotient-slice logic for constant division.
- Divides a WIDTH-bit unsigned dividend by a compile-time constant DIVISOR.
- Retires CHUNK quotient bits per clock, MSB chunk first, and carries the partial remainder between chunks.
- Sits in the datapath in front of consumers of quotient and remainder, behind a valid/ready handshake on both sides.

Parameters:
- WIDTH, 64: dividend and quotient width in bits; must be >= 1.
- DIVISOR, 3: constant divisor; must be >= 2.
- CHUNK, 6: dividend bits consumed per cycle; 1 <= CHUNK <= WIDTH.
- REM_W, $clog2(DIVISOR): remainder width; derived, not overridden.

Ports:
- clk  in  1  single clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  dividend is valid.
- in_ready  out  1  block can accept a dividend.
- dividend  in  WIDTH  unsigned dividend.
- out_valid  out  1  quotient and remainder are valid.
- out_ready  in  1  consumer takes the result.
- quotient  out  WIDTH  floor(dividend / DIVISOR).
- remainder  out  REM_W  dividend mod DIVISOR.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst.
- Reset values: state=IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0, internal remainder=0, chunk index=0.
- NCH = ceil(WIDTH/CHUNK). The dividend is zero-extended to NCH*CHUNK bits; the MSB chunk carries the padding.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready, latch dividend, clear the partial remainder r, set idx=NCH-1, go to BUSY.
  - BUSY: in_ready=0. Each cycle:
    - t = (r << CHUNK) | chunk[idx]; width REM_W+CHUNK, no overflow because r < DIVISOR.
    - qchunk = t / DIVISOR, which always fits CHUNK bits; r = t % DIVISOR.
    - Write qchunk into quotient bits [idx*CHUNK +: CHUNK]; bits above WIDTH are dropped and are always 0.
    - After the idx=0 cycle: remainder=r, go to DONE.
  - DONE: out_valid=1. quotient and remainder are held stable until out_ready.
    - out_ready with in_valid: back-to-back, same edge. in_ready=1 in this case (in_ready = IDLE | (DONE & out_ready)). Latch the new dividend and go to BUSY; out_valid drops.
    - out_ready without in_valid: go to IDLE, out_valid=0.
- Latency: out_valid rises exactly NCH cycles after the accepting edge. Steady-state throughput is one result per NCH+1 cycles.
- quotient and remainder registers change only in BUSY; in IDLE they hold the last result.
- in_valid while BUSY is ignored and not stored. The producer must hold the dividend until in_ready.
- rst in any state aborts the operation and restores all reset values on the next edge. A partial result is never presented.
- DIVISOR power of two: result must still be exact (e.g. DIVISOR=4 gives a shift and a mask).

Optional Feature:
- Macro: CONST_DIV_ZERO_SKIP_EN.
- Defined:
  - On accept, idx starts at the highest chunk holding a nonzero bit, or at 0 if the dividend is 0.
  - Skipped upper quotient chunks are written 0. r=0 is exact for them.
  - Latency = idx_start+1 cycles, minimum 1.
- Undefined: latency is always NCH. No leading-zero detection logic is synthesised.
- Results must be bit-identical in both builds.

Test Plan:
1. WIDTH=64/DIVISOR=3/CHUNK=6, dividend 0xFFFF_FFFF_FFFF_FFFF -> quotient 0x5555_5555_5555_5555, remainder 0, out_valid 11 cycles after accept.
2. Same config, dividends 100 and 2 -> (33, 1) and (0, 2). With CONST_DIV_ZERO_SKIP_EN, latency is 2 for 100 (chunks 1 and 0) and 1 for 2.
3. WIDTH=32/DIVISOR=7/CHUNK=8, dividend 0xFFFF_FFFF -> quotient 0x2492_4924, remainder 3, latency 4.
4. Backpressure: out_ready held 0 for 5 cycles after out_valid -> outputs stable, in_ready=0. out_ready=1 together with in_valid=1 (dividend 9) -> new accept on that edge, result (3, 0) after 11 cycles.
5. Reset mid-BUSY (cycle 5 of 11) -> next cycle: IDLE, in_ready=1, out_valid=0, quotient=0, remainder=0. A new dividend 6 then yields (2, 0).
6. Random sweep, 10k dividends, all legal configs {DIVISOR 3, 5, 7, 10}, {CHUNK 1, 4, 6, 64} -> matches the reference model (dividend/DIVISOR, dividend%DIVISOR) and the latency rule.
